fb_swap_ctrl: RTL and testbench
===============================

// Module: fb_swap_ctrl
// PURPOSE
//  Sequencer/arbiter for the double-buffered framebuffer back-buffer write port.
//  Merges CPU writes with a hardware clear (fill) engine onto one write port.
//  Schedules the front/back buffer swap (BufSel) on the next VBlank rising edge.
//  Raises a latched NMI at VBlank when enabled.
//  Sits between CPU bus decode / config register and the buffer memory muxes.
// PARAMETERS
//  ADDR_W     15      back-buffer address width ({Row[8:2], Col[9:2]})
//  DATA_W     8       pixel width (RRRGGGBB)
//  CLEAR_LEN  32768   words written per clear; 2 <= CLEAR_LEN <= 2**ADDR_W
// PORTS
//  Clock        in   1       single clock; every input is synchronous to it
//  Reset        in   1       asynchronous, active-high
//  CpuWrEn      in   1       one-cycle CPU write strobe to the back buffer
//  CpuAddr      in   ADDR_W  CPU write address
//  CpuData      in   DATA_W  CPU write data
//  SwapReq      in   1       one-cycle request: swap buffers at next VBlank edge
//  ClearReq     in   1       one-cycle request: fill back buffer with ClearColor
//  ClearColor   in   DATA_W  fill value, sampled on an accepted ClearReq
//  VBlank       in   1       vertical blank level from the timing counters
//  NmiEnable    in   1       config bit; gates NMI generation
//  NmiAck       in   1       one-cycle strobe; clears the latched NMI
//  MemWe        out  1       back-buffer write enable (registered)
//  MemAddr      out  ADDR_W  back-buffer write address (registered)
//  MemData      out  DATA_W  back-buffer write data (registered)
//  BufSel       out  1       displayed-buffer select
//  SwapPending  out  1       swap requested, not yet performed
//  ClearBusy    out  1       clear engine running
//  ClearDone    out  1       one-cycle pulse after the last clear word is issued
//  Nmi_n        out  1       active-low NMI, level until acknowledged
// BEHAVIOUR
//  - Reset values:
//    - MemWe=0, MemAddr=0, MemData=0, BufSel=0.
//    - SwapPending=0, ClearBusy=0, ClearDone=0, Nmi_n=1.
//    - Clear FSM=IDLE, clear counter=0, VBlank history=0.
//  - Reset asserted mid-clear aborts the clear. Nothing resumes after release.
//  - Write port arbitration (latency 1: decision in cycle N, outputs in N+1):
//    - CpuWrEn=1: MemWe=1, MemAddr=CpuAddr, MemData=CpuData. CPU always wins.
//    - Else, if the FSM is in RUN: MemWe=1, MemAddr=counter, MemData=latched colour;
//      counter += 1.
//    - Else: MemWe=0. MemAddr and MemData hold their previous values.
//    - A CPU write during RUN stalls the counter for that cycle. No word is skipped.
//  - Clear FSM:
//    - IDLE -> RUN on ClearReq. The transition latches ClearColor and zeroes the counter.
//    - RUN -> IDLE in the cycle the word at CLEAR_LEN-1 is issued.
//      ClearDone pulses with that final MemWe.
//    - ClearReq while in RUN is ignored.
//    - ClearBusy = (state == RUN).
//  - Swap:
//    - Edge = VBlank & ~VBlank_q.
//    - SwapReq sets SwapPending. SwapReq while already pending has no further effect.
//    - Swap happens on an edge when (SwapPending | SwapReq) & ~ClearBusy.
//      BufSel toggles and SwapPending clears in the same cycle.
//    - If ClearBusy is 1 at the edge, the swap is deferred to the next edge.
//      SwapPending holds.
//    - SwapReq coincident with a clear-free edge swaps on that edge.
//      SwapPending never goes to 1 in that case.
//  - NMI:
//    - On an edge with NmiEnable=1, Nmi_n becomes 0.
//    - NmiAck sets Nmi_n back to 1.
//    - If an edge and NmiAck coincide, the set wins.
//    - NmiEnable falling does not clear a latched NMI.
//  - Width: the counter is ADDR_W+1 bits internally, so CLEAR_LEN = 2**ADDR_W is legal.
// STRUCTURE
//  - Shared package fb_pkg:
//    - FB_ADDR_W=15, FB_DATA_W=8, FB_WORDS=32768.
//    - typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t.
//    - typedef logic [FB_DATA_W-1:0] pixel_t.
//  - One sub-module, fb_clear_engine: FSM, counter and colour latch.
//    - It exposes Req, Busy, Done, Addr, Data, Valid, and a Stall input driven by CpuWrEn.
//  - Arbiter, swap logic and NMI logic live in the top module.
// TESTING  (bench uses CLEAR_LEN=16)
//  1. Reset then idle: all outputs at their reset values.
//     One CpuWrEn with Addr=0x1234, Data=0xE3 -> next cycle MemWe=1, 0x1234, 0xE3.
//  2. ClearReq with ClearColor=0x1C -> 16 consecutive MemWe.
//     Addresses 0..15, data 0x1C. ClearDone pulses on addr 15. ClearBusy drops after it.
//  3. Clear with CpuWrEn at clear cycles 3 and 4 (Addr=0x7FFF, Data=0xFF)
//     -> CPU writes appear in order. Clear addresses still run 0..15 with none missing.
//     Total MemWe count = 18.
//  4. SwapReq with VBlank=0, then a VBlank rise 10 cycles later
//     -> SwapPending=1 until the edge, BufSel 0->1 at the edge.
//     A second swap returns BufSel to 0.
//  5. SwapReq issued during a clear that spans a VBlank edge -> no toggle at that edge.
//     Toggle at the following edge.
//  6. NmiEnable=1, VBlank rises -> Nmi_n=0 and holds until NmiAck.
//     Edge coincident with NmiAck -> Nmi_n stays 0. Reset mid-clear -> ClearBusy=0, Nmi_n=1.

Source files
------------

// File: rtl/fb_swap_ctrl_pkg.sv
// Shared framebuffer constants and types.
// Imported by the swap controller, its clear engine and its interface.
package fb_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 8;
    localparam int FB_WORDS  = 32768;

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

    typedef logic [FB_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/fb_swap_ctrl_if.sv
// Bus between CPU decode / timing logic and the swap controller.
// The slave side is the controller, the master side drives requests.
interface fb_swap_ctrl_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
);
    logic              cpu_wr_en;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              swap_req;
    logic              clear_req;
    logic [DATA_W-1:0] clear_color;
    logic              vblank;
    logic              nmi_enable;
    logic              nmi_ack;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              buf_sel;
    logic              swap_pending;
    logic              clear_busy;
    logic              clear_done;
    logic              nmi_n;

    modport master (
        output cpu_wr_en, cpu_addr, cpu_data,
        output swap_req, clear_req, clear_color,
        output vblank, nmi_enable, nmi_ack,
        input  mem_we, mem_addr, mem_data,
        input  buf_sel, swap_pending,
        input  clear_busy, clear_done, nmi_n
    );

    modport slave (
        input  cpu_wr_en, cpu_addr, cpu_data,
        input  swap_req, clear_req, clear_color,
        input  vblank, nmi_enable, nmi_ack,
        output mem_we, mem_addr, mem_data,
        output buf_sel, swap_pending,
        output clear_busy, clear_done, nmi_n
    );

endinterface

// File: rtl/fb_swap_ctrl_clear.sv
// Back-buffer fill engine: walks addresses 0..CLEAR_LEN-1.
// Pauses on stall so no word is lost to a CPU write.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int DATA_W    = FB_DATA_W,
    parameter int CLEAR_LEN = FB_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              stall,
    input  logic [DATA_W-1:0] color,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Counter has one spare bit so a full 2**ADDR_W clear is representable.
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(CLEAR_LEN - 1);

    clr_state_t        state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] color_q;

    assign busy  = (state == CLR_RUN);
    assign valid = busy & ~stall;
    assign done  = valid & (cnt == LAST);
    assign addr  = cnt[ADDR_W-1:0];
    assign data  = color_q;

    // FSM, address counter and fill colour latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLR_IDLE;
            cnt     <= '0;
            color_q <= '0;
        end else begin
            unique case (state)
                CLR_IDLE: begin
                    if (req) begin
                        state   <= CLR_RUN;
                        cnt     <= '0;
                        color_q <= color;
                    end
                end
                CLR_RUN: begin
                    if (done) begin
                        state <= CLR_IDLE;
                    end else if (valid) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Back-buffer write arbiter, VBlank-aligned buffer swap and NMI latch.
// CPU writes always beat the clear engine on the shared write port.
module fb_swap_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int DATA_W    = FB_DATA_W,
    parameter int CLEAR_LEN = FB_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    fb_swap_ctrl_if.slave        bus
);

    logic              eng_busy;
    logic              eng_done;
    logic              eng_valid;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_data;
    logic              vblank_q;
    logic              vb_edge;
    logic              swap_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              buf_sel;
    logic              swap_pending;
    logic              clear_done;
    logic              nmi_n;

    fb_clear_engine #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLEAR_LEN (CLEAR_LEN)
    ) u_clear (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.clear_req),
        .stall (bus.cpu_wr_en),
        .color (bus.clear_color),
        .busy  (eng_busy),
        .done  (eng_done),
        .valid (eng_valid),
        .addr  (eng_addr),
        .data  (eng_data)
    );

    assign vb_edge = bus.vblank & ~vblank_q;
    // A swap waits out any clear so the new front buffer is complete.
    assign swap_go = vb_edge
                   & (swap_pending | bus.swap_req)
                   & ~eng_busy;

    // Registered write port: CPU first, then clear engine, else idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= eng_done;
            if (bus.cpu_wr_en) begin
                mem_we   <= 1'b1;
                mem_addr <= bus.cpu_addr;
                mem_data <= bus.cpu_data;
            end else if (eng_valid) begin
                mem_we   <= 1'b1;
                mem_addr <= eng_addr;
                mem_data <= eng_data;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    // VBlank history, pending swap and displayed-buffer select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_q     <= 1'b0;
            swap_pending <= 1'b0;
            buf_sel      <= 1'b0;
        end else begin
            vblank_q <= bus.vblank;
            if (swap_go) begin
                swap_pending <= 1'b0;
                buf_sel      <= ~buf_sel;
            end else if (bus.swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    // NMI latch; a new VBlank edge outranks a same-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_n <= 1'b1;
        end else if (vb_edge & bus.nmi_enable) begin
            nmi_n <= 1'b0;
        end else if (bus.nmi_ack) begin
            nmi_n <= 1'b1;
        end
    end

    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_data     = mem_data;
    assign bus.buf_sel      = buf_sel;
    assign bus.swap_pending = swap_pending;
    assign bus.clear_busy   = eng_busy;
    assign bus.clear_done   = clear_done;
    assign bus.nmi_n        = nmi_n;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl with a 16-word clear.
// Expected values are hand-derived from the intended behaviour.
module tb_fb_swap_ctrl;
    import fb_pkg::*;

    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   we_cnt;
    int   k;

    fb_swap_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_swap_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CLEAR_LEN (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cpu_wr_en   = 0;
        bus.cpu_addr    = '0;
        bus.cpu_data    = '0;
        bus.swap_req    = 0;
        bus.clear_req   = 0;
        bus.clear_color = '0;
        bus.vblank      = 0;
        bus.nmi_enable  = 0;
        bus.nmi_ack     = 0;

        // 1. reset values, then one CPU write
        tick();
        tick();
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_data", 32'(bus.mem_data), 0);
        chk("rst_bufsel", 32'(bus.buf_sel), 0);
        chk("rst_pend", 32'(bus.swap_pending), 0);
        chk("rst_busy", 32'(bus.clear_busy), 0);
        chk("rst_done", 32'(bus.clear_done), 0);
        chk("rst_nmi", 32'(bus.nmi_n), 1);
        rst = 0;
        tick();
        chk("idle_we", 32'(bus.mem_we), 0);
        bus.cpu_wr_en = 1;
        bus.cpu_addr  = 15'h1234;
        bus.cpu_data  = 8'hE3;
        tick();
        bus.cpu_wr_en = 0;
        chk("cpu_we", 32'(bus.mem_we), 1);
        chk("cpu_addr", 32'(bus.mem_addr), 32'h1234);
        chk("cpu_data", 32'(bus.mem_data), 32'hE3);
        tick();
        chk("cpu_we_off", 32'(bus.mem_we), 0);
        chk("cpu_addr_hold", 32'(bus.mem_addr), 32'h1234);

        // 2. plain clear of 16 words
        bus.clear_req   = 1;
        bus.clear_color = 8'h1C;
        tick();
        bus.clear_req = 0;
        chk("clr_busy0", 32'(bus.clear_busy), 1);
        chk("clr_we0", 32'(bus.mem_we), 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("clr_we", 32'(bus.mem_we), 1);
            chk("clr_addr", 32'(bus.mem_addr), 32'(i));
            chk("clr_data", 32'(bus.mem_data), 32'h1C);
            chk("clr_done", 32'(bus.clear_done), 32'(i == 15));
            chk("clr_busy", 32'(bus.clear_busy), 32'(i != 15));
        end
        tick();
        chk("clr_end_we", 32'(bus.mem_we), 0);
        chk("clr_end_done", 32'(bus.clear_done), 0);

        // 3. clear with CPU writes stealing cycles 3 and 4
        bus.clear_req   = 1;
        bus.clear_color = 8'h55;
        tick();
        bus.clear_req = 0;
        we_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            bus.cpu_wr_en = (c == 3 || c == 4);
            bus.cpu_addr  = 15'h7FFF;
            bus.cpu_data  = 8'hFF;
            tick();
            if (bus.mem_we) we_cnt++;
            chk("mix_we", 32'(bus.mem_we), 32'(c <= 17));
            if (c <= 17) begin
                chk("mix_addr", 32'(bus.mem_addr),
                    (c < 3) ? 32'(c) :
                    (c < 5) ? 32'h7FFF : 32'(c - 2));
                chk("mix_data", 32'(bus.mem_data),
                    (c == 3 || c == 4) ? 32'hFF : 32'h55);
            end
        end
        bus.cpu_wr_en = 0;
        chk("mix_count", 32'(we_cnt), 18);

        // 4. swap request then VBlank edge 10 cycles later
        bus.swap_req = 1;
        tick();
        bus.swap_req = 0;
        chk("sw_pend", 32'(bus.swap_pending), 1);
        for (int i = 0; i < 9; i++) tick();
        chk("sw_pend_hold", 32'(bus.swap_pending), 1);
        chk("sw_sel_before", 32'(bus.buf_sel), 0);
        bus.vblank = 1;
        tick();
        chk("sw_sel_after", 32'(bus.buf_sel), 1);
        chk("sw_pend_clr", 32'(bus.swap_pending), 0);
        bus.vblank = 0;
        tick();
        bus.swap_req = 1;
        bus.vblank   = 1;
        tick();
        bus.swap_req = 0;
        chk("sw2_sel", 32'(bus.buf_sel), 0);
        chk("sw2_pend", 32'(bus.swap_pending), 0);

        // 5. swap deferred past an edge that lands inside a clear
        bus.vblank = 0;
        tick();
        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        bus.swap_req  = 1;
        tick();
        bus.swap_req = 0;
        chk("def_busy", 32'(bus.clear_busy), 1);
        chk("def_pend", 32'(bus.swap_pending), 1);
        bus.vblank = 1;
        tick();
        chk("def_no_toggle", 32'(bus.buf_sel), 0);
        chk("def_pend_hold", 32'(bus.swap_pending), 1);
        k = 0;
        while (bus.clear_busy && k < 40) begin
            tick();
            k++;
        end
        chk("def_clear_end", 32'(bus.clear_busy), 0);
        bus.vblank = 0;
        tick();
        bus.vblank = 1;
        tick();
        chk("def_toggle", 32'(bus.buf_sel), 1);
        chk("def_pend_clr", 32'(bus.swap_pending), 0);

        // 6. NMI latch, acknowledge, coincident edge, reset mid-clear
        bus.vblank     = 0;
        bus.nmi_enable = 1;
        tick();
        chk("nmi_idle", 32'(bus.nmi_n), 1);
        bus.vblank = 1;
        tick();
        chk("nmi_set", 32'(bus.nmi_n), 0);
        bus.nmi_enable = 0;
        tick();
        tick();
        chk("nmi_hold", 32'(bus.nmi_n), 0);
        bus.nmi_ack = 1;
        tick();
        bus.nmi_ack = 0;
        chk("nmi_ack", 32'(bus.nmi_n), 1);
        bus.vblank = 0;
        tick();
        bus.nmi_enable = 1;
        bus.vblank     = 1;
        bus.nmi_ack    = 1;
        tick();
        bus.nmi_ack = 0;
        chk("nmi_set_wins", 32'(bus.nmi_n), 0);
        bus.vblank    = 0;
        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        tick();
        chk("rc_busy", 32'(bus.clear_busy), 1);
        rst = 1;
        #1;
        chk("rc_busy_rst", 32'(bus.clear_busy), 0);
        chk("rc_nmi_rst", 32'(bus.nmi_n), 1);
        chk("rc_sel_rst", 32'(bus.buf_sel), 0);
        tick();
        rst = 0;
        tick();
        tick();
        chk("rc_no_resume", 32'(bus.clear_busy), 0);
        chk("rc_we_idle", 32'(bus.mem_we), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
